axi_arbiter_2to1: RTL and testbench
===================================

# axi_arbiter_2to1

Two-master to one-slave AXI-lite arbiter that shares the single-port AXI memory slave between two requesters, such as a CPU port and a DMA/test port. It grants one whole transaction at a time with round-robin fairness, muxes the granted master onto the slave channels, and routes the response back. Exactly one transaction is outstanding at any time. The block sits directly in front of the memory slave.

## Interface
- ADDR_W, 32, address width of all AW/AR channels
- DATA_W, 32, data width of all W/R channels
- aclk  in  1  single clock; all state changes on its rising edge
- arst  in  1  reset, asynchronous, active-low
- m0_awvalid/m1_awvalid  in  1  write address valid, per master
- m0_awaddr/m1_awaddr  in  ADDR_W  write address
- m0_awready/m1_awready  out  1  write address ready
- m0_wvalid/m1_wvalid  in  1  write data valid
- m0_wdata/m1_wdata  in  DATA_W  write data
- m0_wready/m1_wready  out  1  write data ready
- m0_bvalid/m1_bvalid  out  1  write response valid
- m0_bresp/m1_bresp  out  2  write response code
- m0_bready/m1_bready  in  1  write response ready
- m0_arvalid/m1_arvalid  in  1  read address valid
- m0_araddr/m1_araddr  in  ADDR_W  read address
- m0_arready/m1_arready  out  1  read address ready
- m0_rvalid/m1_rvalid  out  1  read data valid
- m0_rdata/m1_rdata  out  DATA_W  read data
- m0_rresp/m1_rresp  out  2  read response code
- m0_rready/m1_rready  in  1  read data ready
- s_* (awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready)  out  as above  slave-facing requests
- s_* (awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp)  in  as above  slave-facing responses
- grant  out  2  one-hot owner of the slave; 00 when idle
- busy  out  1  high in WR or RD state

## Operation
- FSM states: IDLE, WR, RD. A registered grant index `g` and a round-robin pointer `rr` are held alongside the state.
- Request from master i: `req_i = mi_awvalid | mi_arvalid`.
- Arbitration happens in IDLE only:
  - If both masters request, master `rr` wins.
  - If only one requests, it wins.
  - If none requests, the FSM stays in IDLE.
- Within the winning master, a write takes priority over a read: awvalid selects WR, otherwise RD.
- WR state:
  - s_awvalid/awaddr/wvalid/wdata/bready are driven from master g.
  - Master g's awready/wready/bvalid/bresp are driven from the slave.
  - Exit to IDLE on the first cycle in which `s_bvalid & mg_bready` is high.
- RD state:
  - s_arvalid/araddr/rready are driven from master g.
  - Master g's arready/rvalid/rdata/rresp are driven from the slave.
  - Exit to IDLE on the first cycle in which `s_rvalid & mg_rready` is high.
- On exit from WR or RD, `rr` is set to the other master (`rr <= ~g`).
- Forwarded paths are combinational muxes gated by state. In IDLE every s_* request output and every master-facing ready/valid output is 0, and data/resp outputs are 0.
- The non-granted master sees all of its outputs at 0 and waits; its valids are not dropped.
- bresp and rresp are passed through unchanged. An out-of-range slave error code, 11, reaches the requester untouched.
- A master dropping awvalid or arvalid mid-transaction does not release the grant. The grant is released only by the response handshake.

## Timing
- Reset (arst low, asynchronous):
  - state = IDLE, rr = 0, g = 0.
  - grant = 00, busy = 0.
  - All master and slave outputs are 0 immediately.
- Reset asserted mid-transaction aborts the transaction. The arbiter is in IDLE on the first edge after release.
- Grant latency: a request sampled in IDLE at edge N gives state WR/RD and a visible s_*valid in cycle N+1.
- Turnaround: after the response handshake at edge K, the arbiter spends cycle K+1 in IDLE with all s_* valids low. The next grant is visible at K+2 at the earliest. This guarantees the slave has returned to its idle state before the next request.
- Back-to-back requests from the same master alternate with a waiting other master. With no competitor, the same master can be re-granted after one IDLE cycle.
- Simultaneous events:
  - Both masters request in the same IDLE cycle: `rr` decides.
  - A new request arriving on the exit cycle is not seen until IDLE.
- No timeout: a slave that never responds holds the grant indefinitely.

## Test plan
- Reset, then m0 writes 0xDEADBEEF to address 0x10 -> grant=01 and s_awaddr=0x10 one cycle after request; m0_bvalid=1 with bresp=00; grant=00 for one cycle after the B handshake.
- m0 and m1 both assert awvalid in the same cycle after reset -> m0 served first, then m1 after the turnaround cycle; m1_awready stays 0 until its grant.
- m0 and m1 request continuously (m0 writes, m1 reads address 0x10) -> grants alternate 01, 10, 01; m1_rdata=0xDEADBEEF with rresp=00.
- m1 asserts awvalid and arvalid together with no competitor -> write is granted first (busy, grant=10, state WR), then the read after the turnaround cycle.
- m0 reads address 0x200 -> m0_rresp=11 passed through; grant released on the rready handshake.
- arst pulled low during WR while m1_bready=0 -> grant=00, busy=0, and all outputs 0 asynchronously; after release, a fresh m0 request is granted normally with rr=0.

Source files
------------

// File: rtl/axi_arbiter_2to1.sv
// Two-master to one-slave AXI-lite arbiter: one whole transaction at a time,
// round-robin between masters, with the response routed back to the owner.
module axi_arbiter_2to1 #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              aclk,
   input  logic              arst,
   // master 0
   input  logic              m0_awvalid,
   input  logic [ADDR_W-1:0] m0_awaddr,
   output logic              m0_awready,
   input  logic              m0_wvalid,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_wready,
   output logic              m0_bvalid,
   output logic [1:0]        m0_bresp,
   input  logic              m0_bready,
   input  logic              m0_arvalid,
   input  logic [ADDR_W-1:0] m0_araddr,
   output logic              m0_arready,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   input  logic              m0_rready,
   // master 1
   input  logic              m1_awvalid,
   input  logic [ADDR_W-1:0] m1_awaddr,
   output logic              m1_awready,
   input  logic              m1_wvalid,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_wready,
   output logic              m1_bvalid,
   output logic [1:0]        m1_bresp,
   input  logic              m1_bready,
   input  logic              m1_arvalid,
   input  logic [ADDR_W-1:0] m1_araddr,
   output logic              m1_arready,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   input  logic              m1_rready,
   // slave
   output logic              s_awvalid,
   output logic [ADDR_W-1:0] s_awaddr,
   input  logic              s_awready,
   output logic              s_wvalid,
   output logic [DATA_W-1:0] s_wdata,
   input  logic              s_wready,
   input  logic              s_bvalid,
   input  logic [1:0]        s_bresp,
   output logic              s_bready,
   output logic              s_arvalid,
   output logic [ADDR_W-1:0] s_araddr,
   input  logic              s_arready,
   input  logic              s_rvalid,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   output logic              s_rready,
   // status
   output logic [1:0]        grant,
   output logic              busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WR   = 2'd1;
   localparam logic [1:0] RD   = 2'd2;

   logic [1:0] state_q, state_d;
   logic       g_q, g_d;
   logic       rr_q, rr_d;
   logic       req0, req1, win, win_aw;
   logic       is_wr, is_rd, wr0, wr1, rd0, rd1;
   logic       g_bready, g_rready;

   assign req0     = m0_awvalid | m0_arvalid;
   assign req1     = m1_awvalid | m1_arvalid;
   assign win      = (req0 & req1) ? rr_q : req1;
   assign win_aw   = win ? m1_awvalid : m0_awvalid;
   assign g_bready = g_q ? m1_bready : m0_bready;
   assign g_rready = g_q ? m1_rready : m0_rready;

   always_ff @(posedge aclk or negedge arst) begin
      if (!arst) begin
         state_q <= IDLE;
         g_q     <= 1'b0;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         rr_q    <= rr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      rr_d    = rr_q;
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               g_d     = win;
               state_d = win_aw ? WR : RD;
            end
         end
         WR: begin
            if (s_bvalid & g_bready) begin
               state_d = IDLE;
               rr_d    = ~g_q;
            end
         end
         RD: begin
            if (s_rvalid & g_rready) begin
               state_d = IDLE;
               rr_d    = ~g_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign is_wr = (state_q == WR);
   assign is_rd = (state_q == RD);
   assign wr0   = is_wr & ~g_q;
   assign wr1   = is_wr &  g_q;
   assign rd0   = is_rd & ~g_q;
   assign rd1   = is_rd &  g_q;

   // requests forwarded from the owner only while its transaction is active
   assign s_awvalid = (wr0 & m0_awvalid) | (wr1 & m1_awvalid);
   assign s_wvalid  = (wr0 & m0_wvalid)  | (wr1 & m1_wvalid);
   assign s_bready  = (wr0 & m0_bready)  | (wr1 & m1_bready);
   assign s_awaddr  = wr0 ? m0_awaddr : (wr1 ? m1_awaddr : '0);
   assign s_wdata   = wr0 ? m0_wdata  : (wr1 ? m1_wdata  : '0);
   assign s_arvalid = (rd0 & m0_arvalid) | (rd1 & m1_arvalid);
   assign s_rready  = (rd0 & m0_rready)  | (rd1 & m1_rready);
   assign s_araddr  = rd0 ? m0_araddr : (rd1 ? m1_araddr : '0);

   assign m0_awready = wr0 & s_awready;
   assign m0_wready  = wr0 & s_wready;
   assign m0_bvalid  = wr0 & s_bvalid;
   assign m0_bresp   = wr0 ? s_bresp : '0;
   assign m0_arready = rd0 & s_arready;
   assign m0_rvalid  = rd0 & s_rvalid;
   assign m0_rdata   = rd0 ? s_rdata : '0;
   assign m0_rresp   = rd0 ? s_rresp : '0;

   assign m1_awready = wr1 & s_awready;
   assign m1_wready  = wr1 & s_wready;
   assign m1_bvalid  = wr1 & s_bvalid;
   assign m1_bresp   = wr1 ? s_bresp : '0;
   assign m1_arready = rd1 & s_arready;
   assign m1_rvalid  = rd1 & s_rvalid;
   assign m1_rdata   = rd1 ? s_rdata : '0;
   assign m1_rresp   = rd1 ? s_rresp : '0;

   assign busy  = is_wr | is_rd;
   assign grant = {busy & g_q, busy & ~g_q};

endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// Randomized bench for axi_arbiter_2to1: reactive masters and memory slave,
// checked each cycle against a transaction-level ownership model.
module tb_axi_arbiter_2to1;
   localparam int AW = 32;
   localparam int DW = 32;

   logic aclk = 1'b0;
   logic arst = 1'b0;
   always #5 aclk = ~aclk;

   // master-side stimulus and observation
   logic [1:0]    mawv, mwv, mbr, marv, mrr;
   logic [AW-1:0] mawaddr [2];
   logic [AW-1:0] maraddr [2];
   logic [DW-1:0] mwdata  [2];
   logic [1:0]    mawr, mwr, mbv, marr, mrv;
   logic [1:0]    mbresp [2];
   logic [1:0]    mrresp [2];
   logic [DW-1:0] mrdata [2];

   // slave side
   logic          s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
   logic [AW-1:0] s_awaddr, s_araddr;
   logic [DW-1:0] s_wdata;
   logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
   logic [1:0]    s_bresp, s_rresp;
   logic [DW-1:0] s_rdata;
   logic [1:0]    grant;
   logic          busy;

   axi_arbiter_2to1 #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .aclk(aclk), .arst(arst),
      .m0_awvalid(mawv[0]), .m0_awaddr(mawaddr[0]), .m0_awready(mawr[0]),
      .m0_wvalid(mwv[0]), .m0_wdata(mwdata[0]), .m0_wready(mwr[0]),
      .m0_bvalid(mbv[0]), .m0_bresp(mbresp[0]), .m0_bready(mbr[0]),
      .m0_arvalid(marv[0]), .m0_araddr(maraddr[0]), .m0_arready(marr[0]),
      .m0_rvalid(mrv[0]), .m0_rdata(mrdata[0]), .m0_rresp(mrresp[0]), .m0_rready(mrr[0]),
      .m1_awvalid(mawv[1]), .m1_awaddr(mawaddr[1]), .m1_awready(mawr[1]),
      .m1_wvalid(mwv[1]), .m1_wdata(mwdata[1]), .m1_wready(mwr[1]),
      .m1_bvalid(mbv[1]), .m1_bresp(mbresp[1]), .m1_bready(mbr[1]),
      .m1_arvalid(marv[1]), .m1_araddr(maraddr[1]), .m1_arready(marr[1]),
      .m1_rvalid(mrv[1]), .m1_rdata(mrdata[1]), .m1_rresp(mrresp[1]), .m1_rready(mrr[1]),
      .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
      .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wready(s_wready),
      .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
      .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
      .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
      .grant(grant), .busy(busy)
   );

   int total = 0;
   int bad   = 0;

   // master pending transactions
   logic [1:0]    wp, awd, rp, ard;
   logic [AW-1:0] wa [2];
   logic [AW-1:0] ra [2];
   logic [DW-1:0] wd [2];
   bit            hold_br, rand_en;

   // slave memory and its independent reference copy
   logic [DW-1:0] smem [64];
   logic [DW-1:0] rmem [64];
   int            sl_st;

   // ownership model: which master holds the slave and for what kind of access
   bit mo_busy, mo_wr;
   int mo_o, mo_rr;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] exp_resp(input logic [AW-1:0] a);
      return (a < 32'h100) ? 2'b00 : 2'b11;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] a;
      a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) a = 32'h200 + a;
      return a;
   endfunction

   task automatic drive();
      for (int i = 0; i < 2; i++) begin
         mawv[i]    = wp[i] & ~awd[i];
         mwv[i]     = wp[i] & ~awd[i];
         marv[i]    = rp[i] & ~ard[i];
         mawaddr[i] = wa[i];
         mwdata[i]  = wd[i];
         maraddr[i] = ra[i];
      end
   endtask

   task automatic slave_idle();
      sl_st = 0;
      s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
      s_bvalid = 1'b0; s_rvalid = 1'b0;
      s_bresp = 2'b00; s_rresp = 2'b00; s_rdata = '0;
   endtask

   task automatic issue_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wp[i] = 1'b1; awd[i] = 1'b0; wa[i] = a; wd[i] = d;
      drive();
   endtask

   task automatic issue_rd(input int i, input logic [AW-1:0] a);
      rp[i] = 1'b1; ard[i] = 1'b0; ra[i] = a;
      drive();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_slv"}, {grant, busy, s_awvalid, s_awaddr, s_wvalid, s_wdata,
                            s_bready, s_arvalid, s_araddr, s_rready}, '0);
      check({tag, "_mst"}, {mawr, mwr, mbv, marr, mrv, mbresp[0], mbresp[1],
                            mrresp[0], mrresp[1], mrdata[0], mrdata[1]}, '0);
   endtask

   task automatic step();
      int            o, w;
      bit            ew, er, done, n_busy, n_wr;
      int            n_o, n_rr;
      logic [AW-1:0] e_awaddr, e_araddr;
      logic [DW-1:0] e_wdata;
      logic [40:0]   e_m, g_m;
      logic [1:0]    hs_aw, hs_b, hs_ar, hs_r;
      int            n_sl;
      logic [1:0]    n_resp;
      logic [DW-1:0] n_rdata;

      @(negedge aclk);
      o  = mo_o;
      ew = mo_busy & mo_wr;
      er = mo_busy & ~mo_wr;
      check("grant", grant, mo_busy ? ((o == 0) ? 2'b01 : 2'b10) : 2'b00);
      check("busy", busy, mo_busy);
      check("s_req", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready},
            {ew & mawv[o], ew & mwv[o], ew & mbr[o], er & marv[o], er & mrr[o]});
      e_awaddr = ew ? mawaddr[o] : '0;
      e_wdata  = ew ? mwdata[o]  : '0;
      e_araddr = er ? maraddr[o] : '0;
      check("s_bus", {s_awaddr, s_wdata, s_araddr}, {e_awaddr, e_wdata, e_araddr});
      for (int i = 0; i < 2; i++) begin
         e_m = '0;
         if (mo_busy && o == i)
            e_m = ew ? {s_awready, s_wready, s_bvalid, s_bresp, 1'b0, 1'b0, 2'b00, 32'd0}
                     : {1'b0, 1'b0, 1'b0, 2'b00, s_arready, s_rvalid, s_rresp, s_rdata};
         g_m = {mawr[i], mwr[i], mbv[i], mbresp[i], marr[i], mrv[i], mrresp[i], mrdata[i]};
         check(i == 0 ? "m0_rsp" : "m1_rsp", g_m, e_m);
      end

      // ownership model next step
      n_busy = mo_busy; n_wr = mo_wr; n_o = mo_o; n_rr = mo_rr;
      if (!mo_busy) begin
         if ((mawv[0] | marv[0]) || (mawv[1] | marv[1])) begin
            if ((mawv[0] | marv[0]) && (mawv[1] | marv[1])) w = mo_rr;
            else w = (mawv[1] | marv[1]) ? 1 : 0;
            n_busy = 1'b1; n_o = w; n_wr = mawv[w];
         end
      end else begin
         done = mo_wr ? (s_bvalid & mbr[o]) : (s_rvalid & mrr[o]);
         if (done) begin
            if (mo_wr) begin
               check("bresp", mbresp[o], exp_resp(wa[o]));
               if (wa[o] < 32'h100) rmem[wa[o][7:2]] = wd[o];
            end else begin
               check("rresp", mrresp[o], exp_resp(ra[o]));
               check("rdata", mrdata[o], (ra[o] < 32'h100) ? rmem[ra[o][7:2]] : '0);
            end
            n_busy = 1'b0; n_rr = 1 - o;
         end
      end

      hs_aw = mawv & mawr; hs_b = mbv & mbr; hs_ar = marv & marr; hs_r = mrv & mrr;

      n_sl = sl_st; n_resp = 2'b00; n_rdata = '0;
      if (sl_st == 0) begin
         if (s_awvalid && s_wvalid && s_awready && s_wready) begin
            n_sl = 1; n_resp = exp_resp(s_awaddr);
            if (s_awaddr < 32'h100) smem[s_awaddr[7:2]] = s_wdata;
         end else if (s_arvalid && s_arready) begin
            n_sl = 2; n_resp = exp_resp(s_araddr);
            n_rdata = (s_araddr < 32'h100) ? smem[s_araddr[7:2]] : '0;
         end
      end else if (sl_st == 1 && s_bready) n_sl = 0;
      else if (sl_st == 2 && s_rready) n_sl = 0;

      @(posedge aclk);
      #1;
      mo_busy = n_busy; mo_wr = n_wr; mo_o = n_o; mo_rr = n_rr;
      for (int i = 0; i < 2; i++) begin
         if (hs_aw[i]) awd[i] = 1'b1;
         if (hs_b[i]) begin wp[i] = 1'b0; awd[i] = 1'b0; end
         if (hs_ar[i]) ard[i] = 1'b1;
         if (hs_r[i]) begin rp[i] = 1'b0; ard[i] = 1'b0; end
         if (rand_en && !wp[i] && $urandom_range(0, 3) == 0) issue_wr(i, rand_addr(), $urandom);
         if (rand_en && !rp[i] && $urandom_range(0, 3) == 0) issue_rd(i, rand_addr());
         mbr[i] = hold_br ? 1'b0 : ($urandom_range(0, 3) != 0);
         mrr[i] = ($urandom_range(0, 3) != 0);
      end
      if (n_sl != sl_st) begin
         if (n_sl == 0) slave_idle();
         else begin
            sl_st = n_sl;
            s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
            s_bvalid = (n_sl == 1); s_rvalid = (n_sl == 2);
            if (n_sl == 1) s_bresp = n_resp;
            else begin s_rresp = n_resp; s_rdata = n_rdata; end
         end
      end
      drive();
   endtask

   task automatic run_until_quiet(input int budget);
      int n = 0;
      while ((mo_busy || wp != 2'b00 || rp != 2'b00) && n < budget) begin
         step();
         n++;
      end
      step();
      check("drain", {mo_busy, wp, rp}, '0);
   endtask

   task automatic tb_state_reset();
      wp = '0; awd = '0; rp = '0; ard = '0;
      mbr = '0; mrr = '0;
      mo_busy = 1'b0; mo_wr = 1'b0; mo_o = 0; mo_rr = 0;
      hold_br = 1'b0;
      slave_idle();
      drive();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin smem[i] = '0; rmem[i] = '0; end
      for (int i = 0; i < 2; i++) begin wa[i] = '0; ra[i] = '0; wd[i] = '0; end
      rand_en = 1'b0;
      tb_state_reset();
      repeat (3) @(posedge aclk);
      #1;
      check_all_zero("rst0");
      arst = 1'b1;
      step();

      issue_wr(0, 32'h10, 32'hDEADBEEF);
      run_until_quiet(50);

      issue_wr(0, 32'h20, 32'h11111111);
      issue_wr(1, 32'h24, 32'h22222222);
      run_until_quiet(50);

      issue_wr(0, 32'h30, 32'h33333333);
      issue_rd(1, 32'h10);
      step();
      issue_wr(0, 32'h34, 32'h44444444);
      run_until_quiet(80);

      issue_wr(1, 32'h38, 32'h55555555);
      issue_rd(1, 32'h38);
      run_until_quiet(50);

      issue_rd(0, 32'h200);
      run_until_quiet(50);

      // abort a write held open by m1 refusing its response
      hold_br = 1'b1;
      issue_wr(1, 32'h3C, 32'h66666666);
      repeat (5) step();
      check("pre_rst_busy", {busy, grant}, 3'b110);
      #2 arst = 1'b0;
      #1;
      check_all_zero("rst_mid");
      tb_state_reset();
      for (int i = 0; i < 64; i++) rmem[i] = smem[i];
      repeat (2) step();
      #2 arst = 1'b1;
      issue_wr(0, 32'h08, 32'h77777777);
      issue_wr(1, 32'h0C, 32'h88888888);
      run_until_quiet(80);

      rand_en = 1'b1;
      repeat (3000) step();
      rand_en = 1'b0;
      run_until_quiet(500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
